// File: rtl/mem_if_arb.sv
// Round-robin arbiter funnelling N mem_if requesters onto one mem_if slave.
// One transaction in flight; the granted request is registered before issue.

package mem_pkg;
    localparam logic [1:0] MEM_READ  = 2'd0;
    localparam logic [1:0] MEM_WRITE = 2'd1;

    typedef struct packed {
        logic [31:0] req_addr;
        logic [31:0] req_data;
        logic [3:0]  req_mask;
        logic [1:0]  req_type;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] resp_data;
        logic        resp_err;
        logic        resp_last;
    } mem_resp_t;
endpackage

// Per-requester steering of ready/valid; only the selected lane sees handshakes.
module mem_if_arb_lane
    import mem_pkg::*;
(
    input  logic      grant_sel,
    input  logic      owner_sel,
    input  logic      in_resp,
    input  logic      s_resp_valid,
    input  mem_resp_t s_resp,
    input  logic      m_resp_ready,
    output logic      m_req_ready,
    output logic      m_resp_valid,
    output mem_resp_t m_resp,
    output logic      resp_ready
);
    assign m_req_ready  = grant_sel;
    assign m_resp_valid = in_resp & owner_sel & s_resp_valid;
    assign m_resp       = s_resp;
    assign resp_ready   = in_resp & owner_sel & m_resp_ready;
endmodule

module mem_if_arb
    import mem_pkg::*;
#(
    parameter int N_MST = 2,
    parameter int ID_W  = (N_MST > 1) ? $clog2(N_MST) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N_MST-1:0]      m_req_valid,
    output logic [N_MST-1:0]      m_req_ready,
    input  mem_req_t [N_MST-1:0]  m_req,
    output logic [N_MST-1:0]      m_resp_valid,
    input  logic [N_MST-1:0]      m_resp_ready,
    output mem_resp_t [N_MST-1:0] m_resp,
    output logic                  s_req_valid,
    input  logic                  s_req_ready,
    output mem_req_t              s_req,
    input  logic                  s_resp_valid,
    output logic                  s_resp_ready,
    input  mem_resp_t             s_resp,
    output logic                  arb_busy,
    output logic [ID_W-1:0]       arb_gnt_id
);
    typedef enum logic [1:0] {IDLE, SREQ, SRESP} state_e;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_MST - 1);

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    mem_req_t        s_req_q, s_req_d;

    logic [ID_W-1:0] win;
    logic            win_vld;
    logic [ID_W-1:0] scan;
    logic [N_MST-1:0] lane_resp_rdy;

    // Scan from rr_ptr upward; wrap by compare so non-power-of-two N works.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        scan    = rr_ptr_q;
        for (int i = 0; i < N_MST; i++) begin
            if (!win_vld && m_req_valid[scan]) begin
                win_vld = 1'b1;
                win     = scan;
            end
            scan = (scan == LAST_ID) ? '0 : scan + 1'b1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < N_MST; k++) begin : g_lane
            mem_if_arb_lane u_lane (
                .grant_sel   ((state_q == IDLE) && win_vld && (win == ID_W'(k))),
                .owner_sel   (gnt_id_q == ID_W'(k)),
                .in_resp     (state_q == SRESP),
                .s_resp_valid(s_resp_valid),
                .s_resp      (s_resp),
                .m_resp_ready(m_resp_ready[k]),
                .m_req_ready (m_req_ready[k]),
                .m_resp_valid(m_resp_valid[k]),
                .m_resp      (m_resp[k]),
                .resp_ready  (lane_resp_rdy[k])
            );
        end
    endgenerate

    assign s_resp_ready = |lane_resp_rdy;
    assign s_req_valid  = (state_q == SREQ);
    assign s_req        = s_req_q;
    assign arb_busy     = (state_q != IDLE);
    assign arb_gnt_id   = gnt_id_q;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_id_d = gnt_id_q;
        s_req_d  = s_req_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    s_req_d  = m_req[win];
                    gnt_id_d = win;
                    state_d  = SREQ;
                end
            end
            SREQ: begin
                if (s_req_ready) state_d = SRESP;
            end
            SRESP: begin
                // Non-last beats keep ownership; only the final beat rotates priority.
                if (s_resp_valid && s_resp_ready && s_resp.resp_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_id_q <= '0;
            s_req_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_id_q <= gnt_id_d;
            s_req_q  <= s_req_d;
        end
    end
endmodule

// File: tb/tb_mem_if_arb.sv
// Directed bench for mem_if_arb (3 requesters) with a transaction-level model
// checked every cycle plus literal expectations from the test plan.
module tb_mem_if_arb;
    import mem_pkg::*;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    m_req_valid, m_req_ready, m_resp_valid, m_resp_ready;
    mem_req_t [N-1:0]  m_req;
    mem_resp_t [N-1:0] m_resp;
    logic            s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
    mem_req_t        s_req;
    mem_resp_t       s_resp;
    logic            arb_busy;
    logic [1:0]      arb_gnt_id;

    int n_chk  = 0;
    int n_pass = 0;
    int grant_q[$];
    int resp_q[$];

    mem_if_arb #(.N_MST(N)) dut (
        .clk(clk), .rstn(rstn),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req(m_req),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp(m_resp),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req(s_req),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp(s_resp),
        .arb_busy(arb_busy), .arb_gnt_id(arb_gnt_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic logic bit_of(input logic [N-1:0] v, input int k);
        logic [N-1:0] t;
        t = v >> k;
        return t[0];
    endfunction

    function automatic int winner(input logic [N-1:0] v, input int pri);
        for (int i = 0; i < N; i++)
            if (bit_of(v, (pri + i) % N)) return (pri + i) % N;
        return -1;
    endfunction

    // Transaction-level model: one outstanding transfer, owner rotates after last beat.
    logic     mdl_busy   = 1'b0;
    logic     mdl_issued = 1'b0;
    int       mdl_owner  = 0;
    int       mdl_pri    = 0;
    mem_req_t mdl_req    = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mdl_busy   <= 1'b0;
            mdl_issued <= 1'b0;
            mdl_owner  <= 0;
            mdl_pri    <= 0;
            mdl_req    <= '0;
        end else if (!mdl_busy) begin
            if (winner(m_req_valid, mdl_pri) >= 0) begin
                mdl_busy   <= 1'b1;
                mdl_issued <= 1'b0;
                mdl_owner  <= winner(m_req_valid, mdl_pri);
                mdl_req    <= m_req[winner(m_req_valid, mdl_pri)];
            end
        end else if (!mdl_issued) begin
            if (s_req_ready) mdl_issued <= 1'b1;
        end else if (s_resp_valid && bit_of(m_resp_ready, mdl_owner) && s_resp.resp_last) begin
            mdl_busy <= 1'b0;
            mdl_pri  <= (mdl_owner + 1) % N;
        end
    end

    always @(negedge clk) begin : cmp
        int w;
        logic [N-1:0] e_rdy, e_rv;
        w     = winner(m_req_valid, mdl_pri);
        e_rdy = (!mdl_busy && w >= 0) ? N'(1 << w) : '0;
        e_rv  = (mdl_busy && mdl_issued && s_resp_valid) ? N'(1 << mdl_owner) : '0;
        check("m_req_ready", 96'(m_req_ready), 96'(e_rdy));
        check("m_resp_valid", 96'(m_resp_valid), 96'(e_rv));
        check("s_req_valid", 96'(s_req_valid), 96'(mdl_busy && !mdl_issued));
        check("s_req", 96'(s_req), 96'(mdl_req));
        check("s_resp_ready", 96'(s_resp_ready),
              96'(mdl_busy && mdl_issued && bit_of(m_resp_ready, mdl_owner)));
        check("arb_busy", 96'(arb_busy), 96'(mdl_busy));
        check("arb_gnt_id", 96'(arb_gnt_id), 96'(mdl_owner));
        check("m_resp0", 96'(m_resp[0]), 96'(s_resp));
        check("m_resp1", 96'(m_resp[1]), 96'(s_resp));
        check("m_resp2", 96'(m_resp[2]), 96'(s_resp));
    end

    always @(posedge clk) begin
        if (rstn) begin
            for (int k = 0; k < N; k++)
                if (bit_of(m_req_valid & m_req_ready, k)) grant_q.push_back(k);
            if (s_resp_valid && s_resp_ready) resp_q.push_back(int'(arb_gnt_id));
        end
    end

    function automatic mem_req_t mk_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        mem_req_t r;
        r.req_addr = a; r.req_data = d; r.req_mask = 4'hF; r.req_type = t;
        return r;
    endfunction

    function automatic mem_resp_t mk_resp(input logic [31:0] d, input logic last);
        mem_resp_t r;
        r.resp_data = d; r.resp_err = 1'b0; r.resp_last = last;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs;
        m_req_valid  = '0;
        m_resp_ready = '1;
        s_req_ready  = 1'b0;
        s_resp_valid = 1'b0;
        s_resp       = '0;
        for (int k = 0; k < N; k++) m_req[k] = '0;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        idle_inputs();
        tick(); tick();
        rstn = 1'b1;
    endtask

    // Run one full transaction for a single requester with immediate slave.
    task automatic solo_txn(input logic [N-1:0] v, input logic [31:0] d);
        m_req_valid = v; tick();
        m_req_valid = '0; s_req_ready = 1'b1; tick();
        s_req_ready = 1'b0; s_resp_valid = 1'b1; s_resp = mk_resp(d, 1'b1); tick();
        s_resp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rstn = 1'b1;
        idle_inputs();
        #1 rstn = 1'b0;
        #1;
        check("rst_busy", 96'(arb_busy), 96'(0));
        check("rst_svalid", 96'(s_req_valid), 96'(0));
        check("rst_gnt", 96'(arb_gnt_id), 96'(0));
        check("rst_sreq", 96'(s_req), 96'(0));
        check("rst_ready", 96'(m_req_ready), 96'(0));
        tick(); tick();
        rstn = 1'b1;

        // Single request
        m_req[0] = mk_req(32'h0C00_1000, 32'h0, MEM_READ);
        m_req_valid = 3'b001;
        #1 check("t1_ready", 96'(m_req_ready), 96'(3'b001));
        tick();
        m_req_valid = '0;
        #1 check("t1_svalid", 96'(s_req_valid), 96'(1));
        check("t1_addr", 96'(s_req.req_addr), 96'(32'h0C00_1000));
        s_req_ready = 1'b1; tick();
        s_req_ready = 1'b0; tick();
        check("t1_busy_wait", 96'(arb_busy), 96'(1));
        s_resp_valid = 1'b1; s_resp = mk_resp(32'hA5, 1'b1);
        #1 check("t1_rvalid", 96'(m_resp_valid), 96'(3'b001));
        check("t1_rdata", 96'(m_resp[0].resp_data), 96'(32'hA5));
        tick();
        s_resp_valid = 1'b0;
        #1 check("t1_busy_done", 96'(arb_busy), 96'(0));

        // Contention: m0 and m1 continuously valid
        do_reset();
        grant_q.delete(); resp_q.delete();
        m_req[0] = mk_req(32'h0C00_0010, 32'h1, MEM_WRITE);
        m_req[1] = mk_req(32'h0C00_0020, 32'h2, MEM_WRITE);
        m_req_valid = 3'b011; s_req_ready = 1'b1;
        s_resp_valid = 1'b1; s_resp = mk_resp(32'hA0, 1'b1);
        repeat (12) tick();
        if (grant_q.size() < 4 || resp_q.size() < 4) begin
            check("t2_count", 96'(grant_q.size()), 96'(4));
        end else begin
            for (int i = 0; i < 4; i++) begin
                check("t2_grant", 96'(grant_q[i]), 96'(i % 2));
                check("t2_owner", 96'(resp_q[i]), 96'(i % 2));
            end
        end

        // Slave backpressure
        do_reset();
        grant_q.delete();
        m_req[0] = mk_req(32'h0C00_2000, 32'h3, MEM_READ);
        m_req[1] = mk_req(32'h0C00_2004, 32'h4, MEM_READ);
        m_req_valid = 3'b001; tick();
        m_req_valid = 3'b010;
        for (int c = 0; c < 6; c++) begin
            s_req_ready = (c == 5);
            #1 check("t3_addr", 96'(s_req.req_addr), 96'(32'h0C00_2000));
            check("t3_ready", 96'(m_req_ready), 96'(0));
            tick();
        end
        s_req_ready = 1'b0;
        check("t3_accepts", 96'(grant_q.size()), 96'(1));
        s_resp_valid = 1'b1; s_resp = mk_resp(32'h33, 1'b1); tick();
        s_resp_valid = 1'b0;
        #1 check("t3_next", 96'(m_req_ready), 96'(3'b010));

        // Response backpressure on m1
        do_reset();
        m_req[1] = mk_req(32'h0C00_3000, 32'h5, MEM_READ);
        m_req_valid = 3'b010; tick();
        m_req_valid = '0; s_req_ready = 1'b1; tick();
        s_req_ready = 1'b0; s_resp_valid = 1'b1; s_resp = mk_resp(32'h5A, 1'b1);
        m_resp_ready = 3'b101;
        for (int c = 0; c < 3; c++) begin
            #1 check("t4_srdy", 96'(s_resp_ready), 96'(0));
            check("t4_rvalid", 96'(m_resp_valid), 96'(3'b010));
            check("t4_data", 96'(m_resp[1].resp_data), 96'(32'h5A));
            tick();
        end
        m_resp_ready = 3'b111;
        #1 check("t4_srdy_go", 96'(s_resp_ready), 96'(1));
        tick();
        s_resp_valid = 1'b0;
        #1 check("t4_done", 96'(arb_busy), 96'(0));

        // Multi-beat response
        do_reset();
        m_req[0] = mk_req(32'h0C00_4000, 32'h6, MEM_READ);
        m_req[1] = mk_req(32'h0C00_4004, 32'h7, MEM_READ);
        m_req_valid = 3'b001; tick();
        m_req_valid = '0; s_req_ready = 1'b1; tick();
        s_req_ready = 1'b0; s_resp_valid = 1'b1; s_resp = mk_resp(32'h11, 1'b0);
        #1 check("t5_beat1", 96'(m_resp_valid), 96'(3'b001));
        tick();
        #1 check("t5_still", 96'(arb_busy), 96'(1));
        s_resp = mk_resp(32'h22, 1'b1);
        #1 check("t5_beat2", 96'(m_resp[0].resp_data), 96'(32'h22));
        tick();
        s_resp_valid = 1'b0;
        #1 check("t5_done", 96'(arb_busy), 96'(0));
        m_req_valid = 3'b011;
        #1 check("t5_rr_once", 96'(m_req_ready), 96'(3'b010));

        // Priority wrap after the highest-index requester
        do_reset();
        m_req[2] = mk_req(32'h0C00_5000, 32'h8, MEM_WRITE);
        solo_txn(3'b100, 32'h44);
        m_req_valid = 3'b110;
        #1 check("t6_wrap", 96'(m_req_ready), 96'(3'b010));
        m_req_valid = '0;

        // Reset mid-transaction
        do_reset();
        m_req[1] = mk_req(32'h0C00_6000, 32'h9, MEM_READ);
        solo_txn(3'b010, 32'h55);
        m_req_valid = 3'b010; tick();
        m_req_valid = '0;
        #1 check("t7_sreq", 96'(s_req_valid), 96'(1));
        #2 rstn = 1'b0;
        #1 check("t7_async_sv", 96'(s_req_valid), 96'(0));
        check("t7_async_busy", 96'(arb_busy), 96'(0));
        check("t7_async_gnt", 96'(arb_gnt_id), 96'(0));
        tick(); tick();
        rstn = 1'b1;
        m_req_valid = 3'b110;
        #1 check("t7_rr_reset", 96'(m_req_ready), 96'(3'b010));
        m_req_valid = 3'b111;
        #1 check("t7_m0_first", 96'(m_req_ready), 96'(3'b001));
        m_req_valid = '0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_if_arb.md
Name: mem_if_arb

Overview:
- Round-robin arbiter that shares one mem_if slave port (e.g. the PLIC/CLINT peripheral segment) between N mem_if requesters (core data port, debug module, DMA).
- One transaction is outstanding at a time. The granted request is registered, issued to the slave, and the slave response is routed back to the owning requester.
- It sits between the requester-side mem_if ports and the peripheral decode. Every peripheral therefore sees a single, well-ordered requester.

Parameters:
- N_MST, 2, number of requester ports (2..8).
- ID_W, $clog2(N_MST) (minimum 1), width of the grant index.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- m_req_valid  input  N_MST  per-requester request valid.
- m_req_ready  output  N_MST  per-requester request ready.
- m_req  input  N_MST x mem_req_t  per-requester request (req_addr, req_data, req_mask, req_type).
- m_resp_valid  output  N_MST  per-requester response valid.
- m_resp_ready  input  N_MST  per-requester response ready.
- m_resp  output  N_MST x mem_resp_t  per-requester response (all lanes carry the slave response).
- s_req_valid  output  1  slave request valid.
- s_req_ready  input  1  slave request ready.
- s_req  output  mem_req_t  registered granted request.
- s_resp_valid  input  1  slave response valid.
- s_resp_ready  output  1  slave response ready.
- s_resp  input  mem_resp_t  slave response.
- arb_busy  output  1  high when not in IDLE.
- arb_gnt_id  output  ID_W  current or last owner index.

Behaviour:
- State machine has three states:
  - IDLE: no transaction outstanding.
  - SREQ: slave request pending.
  - SRESP: waiting for the slave response.
- Reset values:
  - state=IDLE, rr_ptr=0, arb_gnt_id=0.
  - s_req register cleared to all zeros.
  - m_req_ready=0, m_resp_valid=0, s_req_valid=0, s_resp_ready=0, arb_busy=0.
- IDLE arbitration:
  - The winner is the first requester with m_req_valid=1, searching from rr_ptr upward and wrapping modulo N_MST.
  - m_req_ready[winner]=1 combinationally in IDLE; all other bits are 0.
  - If no requester is valid, m_req_ready=0.
- IDLE acceptance (winner handshake):
  - Latch m_req[winner] into s_req and set arb_gnt_id=winner.
  - Next state is SREQ.
  - The slave sees s_req_valid one cycle after master acceptance.
- SREQ:
  - s_req_valid=1 and s_req is held stable.
  - On s_req_ready=1, go to SRESP.
  - m_req_ready=0 for all requesters.
- SRESP:
  - s_resp_ready = m_resp_ready[arb_gnt_id].
  - m_resp_valid[arb_gnt_id] = s_resp_valid; all other bits are 0.
  - m_resp[k] = s_resp for every k.
  - On a response handshake with s_resp.resp_last=1: go to IDLE and set rr_ptr = (arb_gnt_id+1) mod N_MST.
  - On a handshake with resp_last=0: stay in SRESP (multi-beat).
- Same-cycle response: the slave may assert s_resp_valid in the same cycle as s_req_ready. It is only observed once in SRESP, so the minimum round trip is master accept to response in 2 cycles plus slave latency.
- Back-to-back: after SRESP→IDLE, a new grant can be accepted in the immediately following cycle. There is no bubble beyond the IDLE cycle.
- Fairness: a requester holding valid is granted within N_MST transactions. The last owner has lowest priority next round.
- Requester valid deasserted while not granted: ignored, no side effect.
- Ordering: requests are never reordered within one requester; only one transaction is outstanding globally.
- arb_busy = (state != IDLE).
- Asynchronous reset mid-transaction:
  - Returns to IDLE with all outputs at reset values.
  - The in-flight transaction is abandoned and no response is delivered.
- Width rules:
  - rr_ptr and arb_gnt_id are ID_W wide.
  - Wrap uses an explicit compare against N_MST-1, not natural overflow (N_MST may be a non-power-of-two).

Test Plan:
- Single request:
  - Stimulus: m0 read addr 0x0C00_1000 after reset; slave ready=1, response 2 cycles later with data 0xA5.
  - Required: m_req_ready[0]=1 at cycle 0; s_req_valid at cycle 1 with addr 0x0C00_1000; m_resp_valid[0] with data 0xA5; arb_busy drops the cycle after the response handshake.
- Contention:
  - Stimulus: m0 and m1 both valid continuously for 4 transactions.
  - Required: grants alternate 0,1,0,1; arb_gnt_id matches each response owner; m_req_ready is never high for both.
- Slave backpressure:
  - Stimulus: s_req_ready=0 for 5 cycles, then 1.
  - Required: s_req is stable for all 6 cycles and no second master is accepted.
- Response backpressure:
  - Stimulus: m_resp_ready[1]=0 for 3 cycles with s_resp_valid=1.
  - Required: s_resp_ready=0 for those cycles and the data is held; completion occurs on the cycle m_resp_ready[1]=1.
- Multi-beat response:
  - Stimulus: two beats, resp_last=0 then 1.
  - Required: the state stays SRESP after beat 1 and returns to IDLE after beat 2; rr_ptr advances once.
- Reset mid-transaction:
  - Stimulus: assert rstn=0 while in SREQ.
  - Required: s_req_valid=0 immediately (asynchronous); after release the state is IDLE and m0 has priority (rr_ptr=0).
